// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver feeding a show-ahead byte FIFO.
// Both pins are synchronized into clk; one scan-code byte is pushed per good frame.
module ps2_receiver #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ps2_clk,
  input  logic                            ps2_data,
  input  logic                            rd_en,
  output logic [7:0]                      rd_data,
  output logic                            empty,
  output logic                            full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            parity_err,
  output logic                            frame_err,
  output logic                            overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  logic                   fall, bit_in;

  state_t         state, next_state;
  logic [2:0]     bitcnt;
  logic [7:0]     shreg;
  logic           par_bit;
  logic [TW-1:0]  tcnt;
  logic           timeout, eval, push_pending;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           do_push, do_pop;

  // Input synchronizers, preset high to match an idle bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign bit_in = data_sync[SYNC_STAGES-1];

  always_comb begin
    next_state = state;
    eval       = 1'b0;
    // Abort fires on the edge where the idle-time counter would reach TIMEOUT_CYCLES-1
    timeout    = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYCLES - 2));
    if (timeout) begin
      next_state = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!bit_in) next_state = DATA;
        DATA:    if (bitcnt == 3'd7) next_state = PARITY;
        PARITY:  next_state = STOP;
        STOP: begin
          next_state = IDLE;
          eval       = 1'b1;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Frame control: state, bit/idle counters and the one-cycle outcome flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bitcnt       <= '0;
      tcnt         <= '0;
      frame_err    <= 1'b0;
      parity_err   <= 1'b0;
      push_pending <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE)              bitcnt <= '0;
      else if (state == DATA && fall) bitcnt <= bitcnt + 3'd1;
      if (state == IDLE || fall) tcnt <= '0;
      else                       tcnt <= tcnt + TW'(1);
      frame_err    <= timeout | (eval & ~bit_in);
      parity_err   <= eval & bit_in & ~odd_parity_ok(shreg, par_bit);
      push_pending <= eval & bit_in & odd_parity_ok(shreg, par_bit);
    end
  end

  always_ff @(posedge clk) begin
    if (state == DATA && fall)   shreg   <= {bit_in, shreg[7:1]};
    if (state == PARITY && fall) par_bit <= bit_in;
  end

  // FIFO: a full FIFO still accepts a push when the head is popped in the same cycle
  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign do_pop   = rd_en & ~empty;
  assign do_push  = push_pending & (~full | do_pop);
  assign overflow = push_pending & full & ~rd_en;
  assign rd_data  = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: PS/2 frames bit-banged on the pins, FIFO and pulses checked.
module tb_ps2_receiver;

  localparam int TIMEOUT = 5000;

  logic       clk = 1'b0;
  logic       rst, ps2_clk, ps2_data, rd_en;
  logic [7:0] rd_data;
  logic       empty, full, parity_err, frame_err, overflow;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;
  int n_par = 0, n_frm = 0, n_ovf = 0;

  ps2_receiver #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(TIMEOUT), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Pulse tallies sampled between the falling and rising clock edges
  always begin
    @(negedge clk);
    #2;
    if (parity_err) n_par++;
    if (frame_err)  n_frm++;
    if (overflow)   n_ovf++;
  end

  task automatic send_bit(input logic b, input logic pop);
    @(negedge clk);
    ps2_data = b;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    rd_en = pop;
    @(negedge clk);
    rd_en = 1'b0;
    repeat (16) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (9) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input logic pop_at_push);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
    send_bit(par, 1'b0);
    send_bit(stop, pop_at_push);
    repeat (5) @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
    checks++; if (full !== 1'b0)    begin errors++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if (count !== 4'd0)   begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
    checks++; if ({parity_err, frame_err, overflow} !== 3'b000)
      begin errors++; $display("FAIL reset_pulses got %b want 000", {parity_err, frame_err, overflow}); end
  endtask

  task automatic test_single();
    int p0, f0, o0;
    p0 = n_par; f0 = n_frm; o0 = n_ovf;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    checks++; if (empty !== 1'b0)   begin errors++; $display("FAIL single_empty got %b want 0", empty); end
    checks++; if (rd_data !== 8'h1C) begin errors++; $display("FAIL single_data got %h want 1c", rd_data); end
    checks++; if (count !== 4'd1)   begin errors++; $display("FAIL single_count got %0d want 1", count); end
    checks++; if ((n_par - p0) + (n_frm - f0) + (n_ovf - o0) !== 0)
      begin errors++; $display("FAIL single_pulses got %0d want 0", (n_par - p0) + (n_frm - f0) + (n_ovf - o0)); end
    pop();
    checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL single_pop_empty got %b want 1", empty); end
  endtask

  task automatic test_sequence();
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    checks++; if (count !== 4'd2)   begin errors++; $display("FAIL seq_count got %0d want 2", count); end
    checks++; if (rd_data !== 8'hF0) begin errors++; $display("FAIL seq_first got %h want f0", rd_data); end
    pop();
    checks++; if (rd_data !== 8'h1C) begin errors++; $display("FAIL seq_second got %h want 1c", rd_data); end
    pop();
    checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL seq_empty got %b want 1", empty); end
    pop();
    checks++; if (count !== 4'd0)   begin errors++; $display("FAIL seq_pop_on_empty got %0d want 0", count); end
  endtask

  task automatic test_errors();
    int p0, f0;
    p0 = n_par; f0 = n_frm;
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    checks++; if (n_par - p0 !== 1) begin errors++; $display("FAIL parity_pulse got %0d want 1", n_par - p0); end
    checks++; if (n_frm - f0 !== 0) begin errors++; $display("FAIL parity_no_frame got %0d want 0", n_frm - f0); end
    checks++; if (count !== 4'd0)   begin errors++; $display("FAIL parity_count got %0d want 0", count); end
    p0 = n_par; f0 = n_frm;
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    checks++; if (n_frm - f0 !== 1) begin errors++; $display("FAIL stop_pulse got %0d want 1", n_frm - f0); end
    checks++; if (n_par - p0 !== 0) begin errors++; $display("FAIL stop_no_parity got %0d want 0", n_par - p0); end
    checks++; if (count !== 4'd0)   begin errors++; $display("FAIL stop_count got %0d want 0", count); end
  endtask

  task automatic test_overflow(input logic pop_ninth);
    int o0;
    logic [7:0] d;
    for (int i = 1; i <= 8; i++) begin
      d = 8'(i);
      send_frame(d, ~^d, 1'b1, 1'b0);
    end
    checks++; if (full !== 1'b1)  begin errors++; $display("FAIL ovf_full got %b want 1", full); end
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d want 8", count); end
    o0 = n_ovf;
    send_frame(8'h09, 1'b1, 1'b1, pop_ninth);
    if (!pop_ninth) begin
      checks++; if (n_ovf - o0 !== 1) begin errors++; $display("FAIL ovf_pulse got %0d want 1", n_ovf - o0); end
      for (int i = 1; i <= 8; i++) begin
        checks++; if (rd_data !== 8'(i)) begin errors++; $display("FAIL ovf_pop%0d got %h want %h", i, rd_data, 8'(i)); end
        pop();
      end
    end else begin
      checks++; if (n_ovf - o0 !== 0) begin errors++; $display("FAIL ovf_pop_push_pulse got %0d want 0", n_ovf - o0); end
      checks++; if (count !== 4'd8)   begin errors++; $display("FAIL ovf_pop_push_count got %0d want 8", count); end
      for (int i = 2; i <= 9; i++) begin
        checks++; if (rd_data !== 8'(i)) begin errors++; $display("FAIL ovf_pp_pop%0d got %h want %h", i, rd_data, 8'(i)); end
        pop();
      end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_drain_empty got %b want 1", empty); end
  endtask

  task automatic test_timeout();
    int f0, first, hits;
    f0 = n_frm; first = -1; hits = 0;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    // Falling edge is seen two clocks after the pin; the pulse follows it by TIMEOUT cycles
    for (int n = 1; n <= TIMEOUT + 20; n++) begin
      @(posedge clk);
      #1;
      if (n == 20) ps2_clk = 1'b1;
      if (frame_err) begin
        hits++;
        if (first < 0) first = n;
      end
    end
    checks++; if (first !== TIMEOUT + 2) begin errors++; $display("FAIL timeout_cycle got %0d want %0d", first, TIMEOUT + 2); end
    checks++; if (hits !== 1) begin errors++; $display("FAIL timeout_width got %0d want 1", hits); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL timeout_count got %0d want 0", count); end
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    checks++; if (rd_data !== 8'h5A || count !== 4'd1)
      begin errors++; $display("FAIL timeout_recover got %h/%0d want 5a/1", rd_data, count); end
    pop();
  endtask

  task automatic test_reset_mid_frame();
    int p0, f0, o0;
    send_frame(8'h11, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1, 1'b0);
    send_frame(8'h33, 1'b1, 1'b1, 1'b0);
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL midrst_pre_count got %0d want 3", count); end
    p0 = n_par; f0 = n_frm; o0 = n_ovf;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (count !== 4'd0 || empty !== 1'b1)
      begin errors++; $display("FAIL midrst_clear got %0d/%b want 0/1", count, empty); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    checks++; if (count !== 4'd1 || rd_data !== 8'h29)
      begin errors++; $display("FAIL midrst_next got %0d/%h want 1/29", count, rd_data); end
    checks++; if ((n_par - p0) + (n_frm - f0) + (n_ovf - o0) !== 0)
      begin errors++; $display("FAIL midrst_pulses got %0d want 0", (n_par - p0) + (n_frm - f0) + (n_ovf - o0)); end
    pop();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_only_entry got %b want 1", empty); end
  endtask

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_single();
    test_sequence();
    test_errors();
    test_overflow(1'b0);
    test_overflow(1'b1);
    test_timeout();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
